// File: rtl/spart_pkg.sv
// ----------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART bus-master driver:
//   - ioaddr register map (TX/RX buffer, status, divisor low/high)
//   - br_cfg baud-select encoding
//   - driver state enumeration
//   - baud_div(): 16-bit baud divisor for a given br_cfg and clock frequency
// ----------------------------------------------------------------------------
package spart_pkg;

    // SPART register map seen on ioaddr
    localparam logic [1:0] ADDR_TXRX = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // br_cfg encoding
    typedef enum logic [1:0] {
        BR_4800  = 2'b00,
        BR_9600  = 2'b01,
        BR_19200 = 2'b10,
        BR_38400 = 2'b11
    } br_cfg_e;

    // Driver sequencer states
    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD_RX,
        WR_TX,
        GAP
    } drv_state_e;

    // DIV = clk_freq / (16 * baud) - 1, integer truncation, 16 bits wide.
    function automatic logic [15:0] baud_div(input logic [1:0] br_cfg,
                                             input int unsigned clk_freq);
        int unsigned baud;
        int unsigned div;
        baud = 32'd4800;
        case (br_cfg_e'(br_cfg))
            BR_4800:  baud = 32'd4800;
            BR_9600:  baud = 32'd9600;
            BR_19200: baud = 32'd19200;
            BR_38400: baud = 32'd38400;
        endcase
        div = clk_freq / (32'd16 * baud) - 32'd1;
        return div[15:0];
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// ----------------------------------------------------------------------------
// echo_fifo
// Synchronous byte FIFO used as the echo buffer between the SPART receiver
// and transmitter. Pointers wrap naturally; occupancy is a separate counter
// one bit wider than the pointers so full and empty are unambiguous.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears pointers/count)
//   i_push     write i_wdata (ignored when full)
//   i_wdata    byte to write
//   i_pop      drop the head entry (ignored when empty)
//   o_rdata    head entry (valid when !o_empty)
//   o_full     DEPTH entries held
//   o_empty    no entries held
//   o_level    number of entries held
// ----------------------------------------------------------------------------
module echo_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_wdata,
    input  logic                     i_pop,
    output logic [7:0]               o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == LW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values of the others; blocking = here would create order races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; contents are only
    // observable through o_rdata when the count says an entry is valid, and
    // leaving it out of reset lets it map onto plain RAM/flops without a clear.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/spart_driver.sv
// ----------------------------------------------------------------------------
// spart_driver
// Processor stand-in that masters the SPART bus. After reset, and whenever
// br_cfg changes, it writes the baud divisor (DBL then DBH). It then echoes
// traffic: received bytes are read when rda is high, held in echo_fifo, and
// written back to the transmit buffer when tbr is high. One access per cycle,
// each followed by a GAP cycle so rda/tbr can settle.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   br_cfg      baud select (00=4800 .. 11=38400)
//   rda, tbr    SPART receive-data-available / transmit-buffer-ready
//   iocs        chip select (one cycle per access)
//   iorw        1 = read from SPART, 0 = write to SPART
//   ioaddr      SPART register address
//   databus     shared data bus; driven only while iocs=1 and iorw=0
//   cfg_done    divisor programmed for the current br_cfg
//   fifo_level  bytes held in the echo FIFO
// ----------------------------------------------------------------------------
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  br_cfg,
    input  logic                        rda,
    input  logic                        tbr,
    output logic                        iocs,
    output logic                        iorw,
    output logic [1:0]                  ioaddr,
    inout  wire  [7:0]                  databus,
    output logic                        cfg_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    drv_state_e r_state;
    drv_state_e w_next_state;
    logic [1:0] r_br_shadow;
    logic       r_cfg_done;
    logic       r_rst_q;        // high for the cycle(s) following a reset edge
    logic [15:0] w_div;
    logic       w_cfg_change;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_wdata;
    logic [7:0] w_fifo_head;

    assign w_div        = baud_div(r_br_shadow, CLK_FREQ);
    assign w_cfg_change = (r_state == IDLE) && (br_cfg != r_br_shadow);
    assign cfg_done     = r_cfg_done;

    // Drive the bus only during our own write cycles; otherwise leave it to
    // the SPART (reads) or floating (idle).
    assign databus = (iocs && !iorw) ? w_wdata : 8'hzz;

    echo_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (databus),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // State register, br_cfg shadow and cfg_done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CFG_LO;
            r_br_shadow <= br_cfg;
            r_cfg_done  <= 1'b0;
            r_rst_q     <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_rst_q <= 1'b0;
            if (r_state == CFG_HI) begin
                r_cfg_done <= 1'b1;
            end else if (w_cfg_change) begin
                r_br_shadow <= br_cfg;
                r_cfg_done  <= 1'b0;
            end
        end
    end

    // Next-state logic. Reprogramming beats RX, RX beats TX, so a
    // back-to-back receive stream is drained before echoes go out.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CFG_LO: if (!r_rst_q) w_next_state = CFG_HI;
            CFG_HI: w_next_state = GAP;
            IDLE: begin
                if (w_cfg_change)          w_next_state = CFG_LO;
                else if (rda && !w_full)   w_next_state = RD_RX;
                else if (tbr && !w_empty)  w_next_state = WR_TX;
            end
            RD_RX:  w_next_state = GAP;
            WR_TX:  w_next_state = GAP;
            GAP:    w_next_state = IDLE;
            default: w_next_state = CFG_LO;
        endcase
    end

    // Bus outputs and FIFO strobes, decoded from the current state.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = ADDR_TXRX;
        w_wdata = 8'h00;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            CFG_LO: begin
                // Held off while r_rst_q is set so outputs sit at their
                // reset values until the first edge with rst low.
                if (!r_rst_q) begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = ADDR_DBL;
                    w_wdata = w_div[7:0];
                end
            end
            CFG_HI: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = ADDR_DBH;
                w_wdata = w_div[15:8];
            end
            RD_RX: begin
                iocs   = 1'b1;
                w_push = 1'b1;
            end
            WR_TX: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                w_wdata = w_fifo_head;
                w_pop   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
